// File: rtl/wired_rob_alloc.sv
// wired_rob_alloc
//   ROB slot allocator and head/tail pointer manager for the dual-issue
//   backend. It hands out ROB ids to the two dispatch lanes and drives the
//   commit-side read ids. It also tracks occupancy, applies back-pressure and
//   sequences the backend flush: DRAIN until the ROB is empty, then a
//   one-cycle flush pulse (RECOVER), then back to RUN.
//
// Optional feature macro: WIRED_ROB_ALLOC_PERF_EN (allocation-stall counter).
//
// Ports
//   clk, rst       : clock, synchronous active-high reset
//   alloc_req_i    : per-lane allocation request (contiguous from bit0)
//   alloc_ready_o  : every requested lane is granted this cycle
//   alloc_rid_o    : {lane1 id, lane0 id} = {tail+1, tail}
//   c_rrrid_o      : {head+1, head} for the ROB commit read port
//   c_retire_i     : retire count from commit (contiguous, <= count)
//   flush_req_i    : backend flush request (honoured only in RUN)
//   drain_o        : commit retires without architectural effect
//   flush_o        : one-cycle pulse to the ROB flush input
//   count_o        : occupied entries; empty_o / full_o derived from it
//   perf_stall_o   : stall-cycle counter, tied to 0 without the macro

`ifndef _WIRED_PARAM_ROB_LEN
`define _WIRED_PARAM_ROB_LEN 6
`endif

module wired_rob_alloc #(
  parameter int ROB_LEN = `_WIRED_PARAM_ROB_LEN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             alloc_req_i,
  output logic                   alloc_ready_o,
  output logic [2*ROB_LEN-1:0]   alloc_rid_o,
  output logic [2*ROB_LEN-1:0]   c_rrrid_o,
  input  logic [1:0]             c_retire_i,
  input  logic                   flush_req_i,
  output logic                   drain_o,
  output logic                   flush_o,
  output logic [ROB_LEN:0]       count_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [31:0]            perf_stall_o
);

  localparam int CW = ROB_LEN + 1;
  localparam logic [ROB_LEN:0]   DEPTH_V = {1'b1, {ROB_LEN{1'b0}}};
  localparam logic [ROB_LEN-1:0] PTR_ONE = {{(ROB_LEN-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {RUN, DRAIN, RECOVER} state_t;

  state_t             state;
  logic [ROB_LEN-1:0] head;
  logic [ROB_LEN-1:0] tail;
  logic [ROB_LEN:0]   count;
  logic [ROB_LEN:0]   free;
  logic [ROB_LEN:0]   count_nxt;
  logic [1:0]         fire;
  logic [1:0]         n_req;
  logic [1:0]         n_fire;
  logic [1:0]         n_ret;

  function automatic logic [1:0] pop2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

  // Grant is purely from registered state: slots freed by this cycle's
  // retire only become grantable next cycle.
  assign n_req         = pop2(alloc_req_i);
  assign n_ret         = pop2(c_retire_i);
  assign free          = DEPTH_V - count;
  assign alloc_ready_o = (state == RUN) & ~flush_req_i & ~rst & (free >= CW'(n_req));
  assign fire          = alloc_req_i & {2{alloc_ready_o}};
  assign n_fire        = pop2(fire);
  assign count_nxt     = count + CW'(n_fire) - CW'(n_ret);

  assign alloc_rid_o = {tail + PTR_ONE, tail};
  assign c_rrrid_o   = {head + PTR_ONE, head};
  assign count_o     = count;
  assign empty_o     = (count == '0);
  assign full_o      = (count == DEPTH_V);

  // Pointers are never rewound by a flush: retirement walks head up to tail,
  // so ids remain continuous across the drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      drain_o <= 1'b0;
      flush_o <= 1'b0;
    end else begin
      head  <= head + ROB_LEN'(n_ret);
      tail  <= tail + ROB_LEN'(n_fire);
      count <= count_nxt;
      case (state)
        RUN: begin
          if (flush_req_i) begin
            state   <= DRAIN;
            drain_o <= 1'b1;
          end
        end
        DRAIN: begin
          // Always spends at least one cycle here, even if entered empty.
          if (count_nxt == '0) begin
            state   <= RECOVER;
            drain_o <= 1'b0;
            flush_o <= 1'b1;
          end
        end
        RECOVER: begin
          state   <= RUN;
          flush_o <= 1'b0;
        end
        default: begin
          state   <= RUN;
          drain_o <= 1'b0;
          flush_o <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (alloc_req_i != 2'b10);
      assert (c_retire_i != 2'b10);
      assert (CW'(n_ret) <= count);
      assert (!(state == RECOVER && c_retire_i != 2'b00));
    end
  end

`ifdef WIRED_ROB_ALLOC_PERF_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cnt <= '0;
    end else if ((alloc_req_i != 2'b00) && !alloc_ready_o && (perf_cnt != '1)) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end

  assign perf_stall_o = perf_cnt;
`else
  assign perf_stall_o = 32'd0;
`endif

endmodule

// File: tb/tb_wired_rob_alloc.sv
module tb_wired_rob_alloc;

  localparam int RL = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    alloc_req_i;
  logic          alloc_ready_o;
  logic [2*RL-1:0] alloc_rid_o;
  logic [2*RL-1:0] c_rrrid_o;
  logic [1:0]    c_retire_i;
  logic          flush_req_i;
  logic          drain_o;
  logic          flush_o;
  logic [RL:0]   count_o;
  logic          empty_o;
  logic          full_o;
  logic [31:0]   perf_stall_o;

  int errors = 0;
  int checks = 0;

  wired_rob_alloc #(.ROB_LEN(RL)) dut (
    .clk(clk), .rst(rst),
    .alloc_req_i(alloc_req_i), .alloc_ready_o(alloc_ready_o),
    .alloc_rid_o(alloc_rid_o), .c_rrrid_o(c_rrrid_o),
    .c_retire_i(c_retire_i), .flush_req_i(flush_req_i),
    .drain_o(drain_o), .flush_o(flush_o),
    .count_o(count_o), .empty_o(empty_o), .full_o(full_o),
    .perf_stall_o(perf_stall_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]      req;
    logic [1:0]      ret;
    logic            exp_ready;
    logic [2*RL-1:0] exp_rid;
    logic [2*RL-1:0] exp_rr;
    logic [RL:0]     exp_cnt;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [2*RL-1:0] pr(input int a);
    logic [RL-1:0] lo;
    logic [RL-1:0] hi;
    lo = RL'(a);
    hi = RL'(a + 1);
    return {hi, lo};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change at negedge; combinational outputs are sampled 1ns later.
  task automatic drive(input logic [1:0] req, input logic [1:0] ret, input logic fl);
    @(negedge clk);
    alloc_req_i = req;
    c_retire_i  = ret;
    flush_req_i = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    alloc_req_i = 2'b01;
    c_retire_i  = 2'b00;
    flush_req_i = 1'b0;
    #1;
    chk("ready_in_rst", alloc_ready_o, 0);
    tick();
    rst = 1'b0;
    alloc_req_i = 2'b00;
  endtask

  initial begin
    rst = 1'b1;
    alloc_req_i = 2'b00;
    c_retire_i  = 2'b00;
    flush_req_i = 1'b0;

    vecs[0] = '{req: 2'b00, ret: 2'b00, exp_ready: 1, exp_rid: pr(0), exp_rr: pr(0), exp_cnt: 0};
    vecs[1] = '{req: 2'b01, ret: 2'b00, exp_ready: 1, exp_rid: pr(0), exp_rr: pr(0), exp_cnt: 1};
    vecs[2] = '{req: 2'b11, ret: 2'b00, exp_ready: 1, exp_rid: pr(1), exp_rr: pr(0), exp_cnt: 3};
    vecs[3] = '{req: 2'b11, ret: 2'b01, exp_ready: 1, exp_rid: pr(3), exp_rr: pr(0), exp_cnt: 4};
    vecs[4] = '{req: 2'b00, ret: 2'b11, exp_ready: 1, exp_rid: pr(5), exp_rr: pr(1), exp_cnt: 2};
    vecs[5] = '{req: 2'b01, ret: 2'b11, exp_ready: 1, exp_rid: pr(5), exp_rr: pr(3), exp_cnt: 1};

    do_reset();
    #1;
    chk("rst_count", count_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_drain", drain_o, 0);
    chk("rst_flush", flush_o, 0);
    chk("rst_perf", perf_stall_o, 0);

    // Table-driven basic allocation / retirement
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].req, vecs[i].ret, 1'b0);
      chk($sformatf("v%0d_ready", i), alloc_ready_o, vecs[i].exp_ready);
      chk($sformatf("v%0d_rid", i), alloc_rid_o, vecs[i].exp_rid);
      chk($sformatf("v%0d_rrrid", i), c_rrrid_o, vecs[i].exp_rr);
      tick();
      chk($sformatf("v%0d_count", i), count_o, vecs[i].exp_cnt);
    end

    // Fill, stall, perf, no-bypass boundary
    do_reset();
    for (int i = 0; i < 32; i++) begin
      drive(2'b11, 2'b00, 1'b0);
      tick();
    end
    chk("fill_full", full_o, 1);
    chk("fill_count", count_o, 64);
    drive(2'b01, 2'b00, 1'b0);
    chk("full_ready", alloc_ready_o, 0);
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(2'b01, 2'b00, 1'b0);
      tick();
    end
`ifdef WIRED_ROB_ALLOC_PERF_EN
    chk("perf_7", perf_stall_o, 7);
`else
    chk("perf_off", perf_stall_o, 0);
`endif
    drive(2'b00, 2'b01, 1'b0);
    tick();
    chk("b_count63", count_o, 63);
    drive(2'b11, 2'b11, 1'b0);
    chk("b_nobypass", alloc_ready_o, 0);
    tick();
    chk("b_count61", count_o, 61);
    drive(2'b11, 2'b00, 1'b0);
    chk("b_grant", alloc_ready_o, 1);
    tick();
    chk("b_count63b", count_o, 63);
    do_reset();
    #1;
    chk("perf_rst", perf_stall_o, 0);
    chk("rst2_count", count_o, 0);

    // Pointer wrap: walk tail to 63 while keeping occupancy at 2
    drive(2'b01, 2'b00, 1'b0);
    tick();
    drive(2'b11, 2'b01, 1'b0);
    tick();
    for (int i = 0; i < 30; i++) begin
      drive(2'b11, 2'b11, 1'b0);
      tick();
    end
    drive(2'b11, 2'b11, 1'b0);
    chk("w_ready", alloc_ready_o, 1);
    chk("w_rid", alloc_rid_o, {6'd0, 6'd63});
    chk("w_rr61", c_rrrid_o, {6'd62, 6'd61});
    tick();
    drive(2'b00, 2'b11, 1'b0);
    chk("w_rr63", c_rrrid_o, {6'd0, 6'd63});
    chk("w_tail1", alloc_rid_o, {6'd2, 6'd1});
    tick();
    chk("w_empty", empty_o, 1);

    // Flush with 5 outstanding entries (head=tail=1 now)
    drive(2'b11, 2'b00, 1'b0); tick();
    drive(2'b11, 2'b00, 1'b0); tick();
    drive(2'b01, 2'b00, 1'b0); tick();
    chk("f_count5", count_o, 5);
    drive(2'b01, 2'b01, 1'b1);
    chk("f_req_ready", alloc_ready_o, 0);
    tick();
    chk("f_drain", drain_o, 1);
    chk("f_count4", count_o, 4);
    drive(2'b01, 2'b11, 1'b0);
    chk("f_drain_ready", alloc_ready_o, 0);
    tick();
    chk("f_count2", count_o, 2);
    chk("f_noflush", flush_o, 0);
    drive(2'b00, 2'b11, 1'b0);
    tick();
    chk("f_flush", flush_o, 1);
    chk("f_drain_off", drain_o, 0);
    drive(2'b01, 2'b00, 1'b0);
    chk("f_recover_ready", alloc_ready_o, 0);
    tick();
    chk("f_flush_pulse", flush_o, 0);
    drive(2'b00, 2'b00, 1'b0);
    chk("f_run_ready", alloc_ready_o, 1);
    chk("f_head_tail", c_rrrid_o, alloc_rid_o);
    chk("f_tail6", alloc_rid_o, pr(6));

    // Flush while already empty: one DRAIN cycle, then RECOVER
    drive(2'b00, 2'b00, 1'b1);
    tick();
    chk("e_drain", drain_o, 1);
    drive(2'b00, 2'b00, 1'b0);
    tick();
    chk("e_flush", flush_o, 1);
    drive(2'b00, 2'b00, 1'b0);
    tick();
    chk("e_flush_end", flush_o, 0);
    chk("e_run_ready", alloc_ready_o, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
